instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 60 ++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program-word store that issues instructions over a valid/ready handshake
module instr_fetch #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    input  logic [4:0] prog_len,
    input  logic       start,
    output logic [7:0] sig,
    output logic       sig_valid,
    input  logic       sig_ready,
    output logic [3:0] pc,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [4:0] len;
    logic go, xfer, last;
    assign go = state == IDLE && start && prog_len != 5'd0;
    assign xfer = state == RUN && sig_ready;
    assign last = {1'b0, pc} == len - 5'd1 || sig == 8'hFF;
    assign sig_valid = state == RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        state_nx = go ? RUN : (xfer && last) ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (state == IDLE && load_en) begin
            mem[load_addr] <= load_data;
        end
    end
    // a write to address 0 in the start cycle is forwarded so the first word is current
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 8'h00;
            pc  <= 4'd0;
            len <= 5'd0;
        end else if (go) begin
            len <= prog_len > 5'(DEPTH) ? 5'(DEPTH) : prog_len;
            pc  <= 4'd0;
            sig <= (load_en && load_addr == 4'd0) ? load_data : mem[0];
        end else if (xfer && !last) begin
            pc  <= pc + 4'd1;
            sig <= mem[pc + 4'd1];
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven directed checks of instr_fetch issue, handshake, halt and reset
module tb_instr_fetch;
    logic       clk = 0;
    logic       rst_n;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic [4:0] prog_len;
    logic       start;
    logic [7:0] sig;
    logic       sig_valid;
    logic       sig_ready;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .sig(sig),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w4;
        logic [4:0]  plen;
        logic [15:0] rpat;
        int          exp_n;
        int          exp_done;
        logic [7:0]  exp_last;
        logic [3:0]  exp_lpc;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] img[16];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en = 1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 0;
    endtask

    // expects to be called at a negedge with the DUT idle
    task automatic run(input logic [4:0] plen, input logic [15:0] rp, output int nx,
                       output int nd, output logic [7:0] lw, output logic [3:0] lpc);
        logic [7:0] ps;
        logic [3:0] ppc;
        logic held;
        nx = 0; nd = 0; lw = 0; lpc = 0; held = 0; ps = 0; ppc = 0;
        start = 1; prog_len = plen;
        @(negedge clk);
        start = 0; prog_len = 5'd7;
        for (int k = 0; k < 60 && nd == 0; k++) begin
            if (done) begin
                nd = 1; start = 1; prog_len = 5'd4;
                @(negedge clk);
                start = 0;
                chk("idle_after_done", {29'd0, busy, sig_valid, done}, 32'd0);
            end else begin
                if (held) begin
                    chk("hold_sig", sig, ps);
                    chk("hold_pc", pc, ppc);
                end
                sig_ready = rp[k % 16];
                if (sig_valid) chk("busy_in_run", busy, 1);
                held = sig_valid && !sig_ready;
                ps = sig; ppc = pc;
                if (sig_valid && sig_ready) begin
                    chk("xfer_sig", sig, (nx < 16) ? img[nx] : 8'hxx);
                    chk("xfer_pc", pc, nx);
                    lw = sig; lpc = pc; nx++;
                end
                @(negedge clk);
            end
        end
        sig_ready = 0;
    endtask

    initial begin
        int nx, nd, ok;
        logic [7:0] lw;
        logic [3:0] lpc;
        vecs[0] = '{32'hC810A193, 5'd4,  16'hFFFF, 4,  1, 8'hC8, 4'd3};
        vecs[1] = '{32'hC810A193, 5'd4,  16'h9999, 4,  1, 8'hC8, 4'd3};
        vecs[2] = '{32'h0010FF93, 5'd3,  16'hFFFF, 2,  1, 8'hFF, 4'd1};
        vecs[3] = '{32'hC810A193, 5'd0,  16'hFFFF, 0,  0, 8'h00, 4'd0};
        vecs[4] = '{32'hC810A193, 5'd20, 16'hFFFF, 16, 1, 8'h4F, 4'd15};
        vecs[5] = '{32'hC810A193, 5'd16, 16'h5555, 16, 1, 8'h4F, 4'd15};
        vecs[6] = '{32'hC810A193, 5'd1,  16'hFFFF, 1,  1, 8'h93, 4'd0};
        vecs[7] = '{32'h000000FF, 5'd4,  16'hFFFF, 1,  1, 8'hFF, 4'd0};
        rst_n = 0; load_en = 0; load_addr = 0; load_data = 0;
        prog_len = 0; start = 0; sig_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {19'd0, sig, sig_valid, pc, busy, done}, 32'd0);
        rst_n = 1;
        @(negedge clk);
        for (int i = 4; i < 16; i++) begin
            img[i] = 8'h40 + 8'(i);
            load(4'(i), img[i]);
        end
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) begin
                img[i] = vecs[v].w4[8*i +: 8];
                load(4'(i), img[i]);
            end
            run(vecs[v].plen, vecs[v].rpat, nx, nd, lw, lpc);
            chk($sformatf("v%0d_count", v), nx, vecs[v].exp_n);
            chk($sformatf("v%0d_done", v), nd, vecs[v].exp_done);
            chk($sformatf("v%0d_last_sig", v), lw, vecs[v].exp_last);
            chk($sformatf("v%0d_last_pc", v), lpc, vecs[v].exp_lpc);
        end

        // writes during RUN must be dropped
        for (int i = 0; i < 4; i++) begin
            img[i] = vecs[0].w4[8*i +: 8];
            load(4'(i), img[i]);
        end
        start = 1; prog_len = 5'd4;
        @(negedge clk);
        start = 0; load_en = 1; load_addr = 4'd1; load_data = 8'h55;
        @(negedge clk);
        load_en = 0;
        chk("run_hold_first", sig, 8'h93);
        sig_ready = 1;
        ok = 0;
        for (int k = 0; k < 20 && ok == 0; k++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        sig_ready = 0;
        chk("run_load_done_seen", ok, 1);
        @(negedge clk);
        run(5'd4, 16'hFFFF, nx, nd, lw, lpc);
        chk("rerun_count", nx, 4);

        // load and start in the same cycle at address 0
        load_en = 1; load_addr = 4'd0; load_data = 8'h77; start = 1; prog_len = 5'd1;
        @(negedge clk);
        load_en = 0; start = 0;
        chk("bypass_sig", sig, 8'h77);
        chk("bypass_valid", sig_valid, 1);
        chk("bypass_pc", pc, 0);
        img[0] = 8'h77;
        sig_ready = 1;
        @(negedge clk);
        sig_ready = 0;
        chk("bypass_done", done, 1);
        @(negedge clk);

        // asynchronous reset in the middle of a run
        start = 1; prog_len = 5'd4;
        @(negedge clk);
        start = 0; sig_ready = 1;
        ok = 0;
        for (int k = 0; k < 10 && ok == 0; k++) begin
            if (pc == 4'd2 && sig_valid) ok = 1;
            else @(negedge clk);
        end
        sig_ready = 0;
        chk("reached_pc2", ok, 1);
        #2 rst_n = 0;
        #1 chk("async_reset_outputs", {19'd0, sig, sig_valid, pc, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        @(negedge clk);
        run(5'd1, 16'hFFFF, nx, nd, lw, lpc);
        chk("post_reset_count", nx, 1);
        chk("post_reset_word", lw, 8'h00);
        chk("post_reset_done", nd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
